// File: rtl/regfile_mp.sv
// Multi-port register file: NR combinational read ports, two write ports
// (port 1 wins on collision), optional same-cycle write-to-read bypass,
// optional hardwired-zero register 0 and a sequenced soft-clear engine.
module regfile_mp #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [DW-1:0]    wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [DW-1:0]    wd1,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] idx;
    logic [DW-1:0] regs [DEPTH];

    // Write ports are only live while no clear sequence is running
    logic wr0_ok, wr1_ok;
    logic wr0_store, wr1_store;

    assign wr0_ok    = we0 && !busy;
    assign wr1_ok    = we1 && !busy;
    assign wr0_store = wr0_ok && !((ZERO_REG != 0) && (wa0 == '0));
    assign wr1_store = wr1_ok && !((ZERO_REG != 0) && (wa1 == '0));

    // Clear sequencer: IDLE -> CLEAR (DEPTH cycles) -> DONE (one cycle) -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (idx == LAST_IDX) begin
                        // Last entry cleared this edge; hold idx rather than wrap
                        state    <= DONE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Register array: clear engine owns the array while busy, otherwise
    // port 0 then port 1 write so port 1 wins an address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[idx] <= '0;
        end else begin
            if (wr0_store) begin
                regs[wa0] <= wd0;
            end
            if (wr1_store) begin
                regs[wa1] <= wd1;
            end
        end
    end

    // Read ports: array lookup, optional forwarding of this cycle's write data
    genvar gi;
    generate
        for (gi = 0; gi < NR; gi++) begin : g_rd
            logic [AW-1:0] ra;
            logic [DW-1:0] rd_val;

            assign ra = rd_addr[gi*AW +: AW];

            // Forwarding priority: port 1, then port 0, then stored value
            always_comb begin
                rd_val = regs[ra];
                if (BYPASS != 0) begin
                    if (wr1_ok && (wa1 == ra)) begin
                        rd_val = wd1;
                    end else if (wr0_ok && (wa0 == ra)) begin
                        rd_val = wd0;
                    end
                end
                if ((ZERO_REG != 0) && (ra == '0)) begin
                    rd_val = '0;
                end
            end

            assign rd_data[gi*DW +: DW] = rd_val;
        end
    endgenerate

endmodule
